prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and state encoding for the boot-time
// program loader. Imported by the RTL and the bench so both decode the
// frame-start byte and states identically.
package prog_loader_pkg;

  localparam int unsigned ADDR_W = 8;   // program-memory address width
  localparam int unsigned DATA_W = 8;   // stream byte / memory word width
  localparam int unsigned CNT_W  = 9;   // remaining-byte counter (holds 256)

  localparam logic [DATA_W-1:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: accepts a framed byte stream (SYNC, LEN, payload, CSUM) over
// valid/ready, writes the payload into program memory from address 0x00 and
// holds the core in reset until a frame with a good checksum is loaded.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_data/valid   stream byte and its valid
//   in_ready        loader can accept a byte (low only while the core runs)
//   reload          one-cycle request to return to IDLE
//   mem_addr/wdata  program-memory write port, strobed by mem_we
//   core_rst        reset to the core, low only after a good image
//   done            good image loaded, core running
//   err             last frame failed its checksum
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              in_ready_q, core_rst_q, done_q, err_q;

  logic              xfer_c;
  logic [DATA_W-1:0] csum_c;

  assign xfer_c = in_valid && in_ready_q;
  assign csum_c = sum_q + in_data;

  // Next-state and write-port logic; reload overrides any byte transfer.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (reload) begin
      state_d = ST_IDLE;
    end else if (xfer_c) begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (in_data == SYNC) state_d = ST_LEN;
        end
        ST_LEN: begin
          // LEN = 0 encodes a full 256-byte image
          rem_d   = (in_data == '0) ? CNT_W'(256) : CNT_W'(in_data);
          sum_d   = '0;
          addr_d  = '0;
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          sum_d       = csum_c;
          rem_d       = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          state_d = (csum_c == '0) ? ST_RUN : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs (status decoded from next state
  // so it changes on the same edge as the state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      sum_q       <= '0;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= (state_d != ST_RUN);
      core_rst_q  <= (state_d != ST_RUN);
      done_q      <= (state_d == ST_RUN);
      err_q       <= (state_d == ST_ERR);
    end
  end

  assign in_ready  = in_ready_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
